// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back queue.
// The optional forwarding path in reg_wb_match is enabled by defining WB_FORWARD_EN.
package wb_pkg;

  localparam int WB_W     = 8;
  localparam int WB_D     = 3;
  localparam int WB_DEPTH = 4;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_PORT1 = 2'b01;
  localparam logic [1:0] RW_PORT2 = 2'b10;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [WB_D-1:0] dst;
    logic [WB_W-1:0] value;
    logic            port;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_match.sv
// Per-entry register-index compare and youngest-match value select.
// The value select exists only when WB_FORWARD_EN is defined; otherwise value_o is 0.
module reg_wb_match #(
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][D-1:0]       regs_i,
  input  logic [DEPTH-1:0][W-1:0]       values_i,
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [$clog2(DEPTH)-1:0]      head_i,
  input  logic [D-1:0]                  query_i,
  output logic                          busy_o,
  output logic [W-1:0]                  value_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] hit;

  always_comb begin
    hit = '0;
    for (int s = 0; s < DEPTH; s++) begin
      hit[s] = valid_i[s] && (regs_i[s] == query_i);
    end
  end

  assign busy_o = |hit;

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest from the head so the last hit seen is the youngest.
  always_comb begin
    logic [AW-1:0] slot;
    value_o = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_i + AW'(i);
      if (hit[slot]) value_o = values_i[slot];
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{values_i, head_i};
  assign value_o    = '0;
`endif

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order pending-write FIFO driving the register file write port, with a busy lookup.
// Define WB_FORWARD_EN to drive QueryValue with the youngest pending value for QueryReg.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int W     = WB_W,
  parameter int D     = WB_D,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [D-1:0]                 InReg,
  input  logic [W-1:0]                 InValue,
  input  logic                         InPort,
  input  logic                         Stall,
  input  logic                         Flush,
  output logic [1:0]                   RegWrite,
  output logic [D-1:0]                 WriteReg,
  output logic [W-1:0]                 WriteValue,
  input  logic [D-1:0]                 QueryReg,
  output logic                         QueryBusy,
  output logic [W-1:0]                 QueryValue,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic [1:0]                   State
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: an entry is stored when InValid && InReady at the rising edge and Flush is low.
  logic [DEPTH-1:0][D-1:0] reg_q;
  logic [DEPTH-1:0][W-1:0] val_q;
  logic [DEPTH-1:0]        port_q;
  logic [AW-1:0]           rd_q, rd_d;
  logic [AW-1:0]           wr_q, wr_d;
  logic [CW-1:0]           count_q, count_d;
  wb_state_t               state_q;

  logic                    push, pop;
  logic [DEPTH-1:0]        slot_valid;

  assign InReady = (count_q < CW'(DEPTH));
  assign push    = InValid && InReady && !Flush;
  assign pop     = (count_q != '0) && !Stall && !Flush;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (Flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      port_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (push) begin
        reg_q[wr_q]  <= InReg;
        val_q[wr_q]  <= InValue;
        port_q[wr_q] <= InPort;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
    end else if (Flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (push) state_q <= ACTIVE;
        ACTIVE: begin
          if (count_d == CW'(DEPTH)) state_q <= FULL;
          else if (count_d == '0)    state_q <= EMPTY;
        end
        FULL:    if (pop) state_q <= ACTIVE;
        default: state_q <= EMPTY;
      endcase
    end
  end

  // A slot holds a live entry when its distance from the head is below Count.
  always_comb begin
    logic [AW-1:0] offset;
    slot_valid = '0;
    offset     = '0;
    for (int s = 0; s < DEPTH; s++) begin
      offset        = AW'(s) - rd_q;
      slot_valid[s] = (count_q == CW'(DEPTH)) || (CW'(offset) < count_q);
    end
  end

  reg_wb_match #(
    .W     (W),
    .D     (D),
    .DEPTH (DEPTH)
  ) u_match (
    .regs_i   (reg_q),
    .values_i (val_q),
    .valid_i  (slot_valid),
    .head_i   (rd_q),
    .query_i  (QueryReg),
    .busy_o   (QueryBusy),
    .value_o  (QueryValue)
  );

  assign RegWrite   = pop ? (port_q[rd_q] ? RW_PORT2 : RW_PORT1) : RW_NONE;
  assign WriteReg   = pop ? reg_q[rd_q] : '0;
  assign WriteValue = pop ? val_q[rd_q] : '0;
  assign Count      = count_q;
  assign State      = state_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Table-driven bench for reg_writeback_queue plus a hand-written mid-queue reset sequence.
module tb_reg_writeback_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_port, stall, flush;
  logic [2:0] in_reg, write_reg, query_reg;
  logic [7:0] in_value, write_value, query_value;
  logic [1:0] reg_write, state;
  logic       query_busy;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_writeback_queue dut (
    .CLK        (clk),
    .Reset      (rst),
    .InValid    (in_valid),
    .InReady    (in_ready),
    .InReg      (in_reg),
    .InValue    (in_value),
    .InPort     (in_port),
    .Stall      (stall),
    .Flush      (flush),
    .RegWrite   (reg_write),
    .WriteReg   (write_reg),
    .WriteValue (write_value),
    .QueryReg   (query_reg),
    .QueryBusy  (query_busy),
    .QueryValue (query_value),
    .Count      (count),
    .State      (state)
  );

  typedef struct {
    logic       v;
    logic [2:0] r;
    logic [7:0] val;
    logic       p;
    logic       st;
    logic       fl;
    logic [2:0] q;
    logic [1:0] rw;
    logic [2:0] wr;
    logic [7:0] wv;
    logic [2:0] cnt;
    logic       busy;
    logic [7:0] qv;
    logic       rdy;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  function automatic vec_t mk(int v, int r, int val, int p, int st, int fl, int q,
                              int rw, int wr, int wv, int cnt, int busy, int qv, int rdy);
    vec_t t;
    t.v = v[0];   t.r = r[2:0];   t.val = val[7:0]; t.p = p[0];
    t.st = st[0]; t.fl = fl[0];   t.q = q[2:0];
    t.rw = rw[1:0]; t.wr = wr[2:0]; t.wv = wv[7:0]; t.cnt = cnt[2:0];
    t.busy = busy[0]; t.qv = qv[7:0]; t.rdy = rdy[0];
    return t;
  endfunction

  function automatic logic [1:0] state_of(logic [2:0] c);
    if (c == 3'd0) return 2'd0;
    if (c == 3'd4) return 2'd2;
    return 2'd1;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [2:0] r, logic [7:0] val, logic p,
                       logic st, logic fl, logic [2:0] q);
    in_valid = v; in_reg = r; in_value = val; in_port = p;
    stall = st; flush = fl; query_reg = q;
  endtask

  initial begin
    // Queue starts empty; each row: inputs for the cycle, outputs expected before the edge.
    vecs[0]  = mk(1,4,'h3C,0,0,0,4, 0,0,0,    0,0,0,    1);
    vecs[1]  = mk(0,0,0,   0,0,0,4, 1,4,'h3C, 1,1,'h3C, 1);
    vecs[2]  = mk(0,0,0,   0,0,0,4, 0,0,0,    0,0,0,    1);
    vecs[3]  = mk(1,1,'hA1,0,1,0,1, 0,0,0,    0,0,0,    1);
    vecs[4]  = mk(1,2,'hA2,1,1,0,1, 0,0,0,    1,1,'hA1, 1);
    vecs[5]  = mk(1,3,'hA3,0,1,0,2, 0,0,0,    2,1,'hA2, 1);
    vecs[6]  = mk(1,4,'hA4,1,1,0,4, 0,0,0,    3,0,0,    1);
    vecs[7]  = mk(1,7,'hFF,0,1,0,4, 0,0,0,    4,1,'hA4, 0);
    vecs[8]  = mk(1,7,'hFF,0,0,0,7, 1,1,'hA1, 4,0,0,    0);
    vecs[9]  = mk(0,0,0,   0,0,0,1, 2,2,'hA2, 3,0,0,    1);
    vecs[10] = mk(0,0,0,   0,0,0,3, 1,3,'hA3, 2,1,'hA3, 1);
    vecs[11] = mk(0,0,0,   0,0,0,4, 2,4,'hA4, 1,1,'hA4, 1);
    vecs[12] = mk(0,0,0,   0,0,0,4, 0,0,0,    0,0,0,    1);
    vecs[13] = mk(1,5,'h11,0,1,0,5, 0,0,0,    0,0,0,    1);
    vecs[14] = mk(1,5,'h22,0,1,0,5, 0,0,0,    1,1,'h11, 1);
    vecs[15] = mk(0,0,0,   0,1,0,5, 0,0,0,    2,1,'h22, 1);
    vecs[16] = mk(0,0,0,   0,0,0,5, 1,5,'h11, 2,1,'h22, 1);
    vecs[17] = mk(0,0,0,   0,0,0,5, 1,5,'h22, 1,1,'h22, 1);
    vecs[18] = mk(0,0,0,   0,0,0,5, 0,0,0,    0,0,0,    1);
    vecs[19] = mk(1,6,'h66,1,1,0,6, 0,0,0,    0,0,0,    1);
    vecs[20] = mk(1,0,'h77,0,1,0,6, 0,0,0,    1,1,'h66, 1);
    vecs[21] = mk(1,3,'h99,0,0,1,6, 0,0,0,    2,1,'h66, 1);
    vecs[22] = mk(0,0,0,   0,0,0,3, 0,0,0,    0,0,0,    1);
    vecs[23] = mk(1,1,'hB1,0,0,0,1, 0,0,0,    0,0,0,    1);
    vecs[24] = mk(1,2,'hB2,1,0,0,1, 1,1,'hB1, 1,1,'hB1, 1);
    vecs[25] = mk(1,3,'hB3,0,0,0,2, 2,2,'hB2, 1,1,'hB2, 1);
    vecs[26] = mk(1,4,'hB4,1,0,0,3, 1,3,'hB3, 1,1,'hB3, 1);
    vecs[27] = mk(1,5,'hB5,0,0,0,4, 2,4,'hB4, 1,1,'hB4, 1);
    vecs[28] = mk(1,6,'hB6,1,0,0,6, 1,5,'hB5, 1,0,0,    1);
    vecs[29] = mk(0,0,0,   0,0,0,6, 2,6,'hB6, 1,1,'hB6, 1);
    vecs[30] = mk(0,0,0,   0,0,0,6, 0,0,0,    0,0,0,    1);

    // Clock/reset
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_count",    0, 32'(count),     0);
    chk("reset_regwrite", 0, 32'(reg_write), 0);
    chk("reset_state",    0, 32'(state),     0);
    chk("reset_ready",    0, 32'(in_ready),  1);
    rst = 1'b0;

    // Mid-queue reset: three stalled entries, then an asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 3'(i + 1), 8'(8'h50 + i), 0, 1, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midq_count",    0, 32'(count),     3);
    chk("midq_regwrite", 0, 32'(reg_write), 1);
    chk("midq_state",    0, 32'(state),     1);
    rst = 1'b1;
    #1;
    chk("midq_rst_count",    0, 32'(count),       0);
    chk("midq_rst_regwrite", 0, 32'(reg_write),   0);
    chk("midq_rst_state",    0, 32'(state),       0);
    chk("midq_rst_wval",     0, 32'(write_value), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      logic [7:0] exp_qv;
      @(negedge clk);
      drive(vecs[i].v, vecs[i].r, vecs[i].val, vecs[i].p, vecs[i].st, vecs[i].fl, vecs[i].q);
      #1;
`ifdef WB_FORWARD_EN
      exp_qv = vecs[i].qv;
`else
      exp_qv = 8'h00;
`endif
      chk("regwrite",   i, 32'(reg_write),   32'(vecs[i].rw));
      chk("write_reg",  i, 32'(write_reg),   32'(vecs[i].wr));
      chk("write_val",  i, 32'(write_value), 32'(vecs[i].wv));
      chk("count",      i, 32'(count),       32'(vecs[i].cnt));
      chk("busy",       i, 32'(query_busy),  32'(vecs[i].busy));
      chk("qvalue",     i, 32'(query_value), 32'(exp_qv));
      chk("in_ready",   i, 32'(in_ready),    32'(vecs[i].rdy));
      chk("state",      i, 32'(state),       32'(state_of(vecs[i].cnt)));
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
